// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage priority layer compositor with runtime palettes and collision flags
//
// Ports:
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   in_valid              : pixel inputs valid this cycle
//   layer_hit, layer_en   : per-layer sprite-box hit and enable mask
//   layer_idx             : per-layer palette index, layer k in [k*IDX_W +: IDX_W]
//   bg_color              : {R,G,B} used when no layer is opaque
//   pal_we/pal_layer/pal_addr/pal_data : palette write port
//   coll_clr              : clears sticky collision flags
//   out_valid, VGA_R/G/B  : composited colour, 2 cycles after the pixel
//   out_layer             : winning layer, NUM_LAYERS = background
//   coll_flags            : sticky layer0-vs-layer k collision flags (bit 0 always 0)
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 8,
    localparam int LAYER_W   = $clog2(NUM_LAYERS + 1),
    localparam int SEL_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        in_valid,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [3*COLOR_W-1:0]        bg_color,
    input  logic                        pal_we,
    input  logic [SEL_W-1:0]            pal_layer,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [3*COLOR_W-1:0]        pal_data,
    input  logic                        coll_clr,
    output logic                        out_valid,
    output logic [COLOR_W-1:0]          VGA_R,
    output logic [COLOR_W-1:0]          VGA_G,
    output logic [COLOR_W-1:0]          VGA_B,
    output logic [LAYER_W-1:0]          out_layer,
    output logic [NUM_LAYERS-1:0]       coll_flags
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [LAYER_W-1:0] BG_LAYER = LAYER_W'(NUM_LAYERS);

    // Palette kept in flops so reset can clear every entry to black.
    logic [3*COLOR_W-1:0] pal_mem [NUM_LAYERS][DEPTH];

    logic [NUM_LAYERS-1:0] opaque;
    logic [LAYER_W-1:0]    win_layer;
    logic [IDX_W-1:0]      win_idx;

    logic                  s1_valid;
    logic [LAYER_W-1:0]    s1_layer;
    logic [IDX_W-1:0]      s1_idx;
    logic [3*COLOR_W-1:0]  s1_bg;
    logic [NUM_LAYERS-1:0] s1_opaque;

    logic [3*COLOR_W-1:0]  s2_color;

    // Scan from the lowest priority upward so the lowest-numbered opaque layer wins.
    always_comb begin
        win_layer = BG_LAYER;
        win_idx   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            opaque[k] = layer_hit[k] & layer_en[k] & (layer_idx[k*IDX_W +: IDX_W] != '0);
        end
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                win_layer = LAYER_W'(k);
                win_idx   = layer_idx[k*IDX_W +: IDX_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_layer  <= BG_LAYER;
            s1_idx    <= '0;
            s1_bg     <= '0;
            s1_opaque <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_layer  <= win_layer;
            s1_idx    <= win_idx;
            s1_bg     <= bg_color;
            s1_opaque <= opaque;
        end
    end

    // Reads the pre-edge palette contents, so a same-edge write is seen one pixel later.
    always_comb begin
        if (s1_layer == BG_LAYER) begin
            s2_color = s1_bg;
        end else begin
            s2_color = pal_mem[s1_layer[SEL_W-1:0]][s1_idx];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    pal_mem[l][a] <= '0;
                end
            end
        end else if (pal_we && (int'(pal_layer) < NUM_LAYERS)) begin
            pal_mem[pal_layer][pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            out_layer <= BG_LAYER;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                {VGA_R, VGA_G, VGA_B} <= s2_color;
                out_layer             <= s1_layer;
            end else begin
                {VGA_R, VGA_G, VGA_B} <= '0;
                out_layer             <= BG_LAYER;
            end
        end
    end

    // Set takes precedence over clear on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            coll_flags <= '0;
        end else begin
            coll_flags[0] <= 1'b0;
            for (int k = 1; k < NUM_LAYERS; k++) begin
                coll_flags[k] <= (coll_flags[k] & ~coll_clr)
                               | (s1_valid & s1_opaque[0] & s1_opaque[k]);
            end
        end
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the single-cycle colour mapper.
- Takes NUM_LAYERS sprite/background layers, each supplying a hit flag and a palette index for the current pixel.
- Picks the highest-priority opaque layer and looks its colour up in a per-layer palette that software/FSM can rewrite at runtime.
- Emits registered VGA RGB with fixed latency, plus sticky collision flags between layer 0 (crosshair) and every other layer.

Parameters:
- NUM_LAYERS, 4: number of layers; layer 0 is highest priority.
- IDX_W, 4: palette index width; index 0 is transparent.
- COLOR_W, 8: width of each of R, G, B.
- LAYER_W, $clog2(NUM_LAYERS+1): width of out_layer (derived, not overridable).

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: pixel inputs valid this cycle (active display area).
- layer_hit, input, NUM_LAYERS: bit k = current pixel lies inside layer k's sprite box.
- layer_idx, input, NUM_LAYERS*IDX_W: palette index of layer k in bits [k*IDX_W +: IDX_W].
- layer_en, input, NUM_LAYERS: per-layer enable mask; sampled with the pixel.
- bg_color, input, 3*COLOR_W: {R,G,B} shown when no layer is opaque.
- pal_we, input, 1: palette write strobe.
- pal_layer, input, $clog2(NUM_LAYERS): palette bank to write.
- pal_addr, input, IDX_W: palette entry to write.
- pal_data, input, 3*COLOR_W: {R,G,B} write data.
- coll_clr, input, 1: clears all collision flags.
- out_valid, output, 1: VGA_R/G/B valid.
- VGA_R, VGA_G, VGA_B, output, COLOR_W each: composited colour.
- out_layer, output, LAYER_W: winning layer number; NUM_LAYERS means background.
- coll_flags, output, NUM_LAYERS: sticky collision flags; bit 0 is always 0.

Behaviour:
- Opaque definition: layer k is opaque when layer_hit[k] & layer_en[k] & (idx_k != 0).
- Stage 1 (edge 1): register in_valid, the lowest-numbered opaque layer W (or NUM_LAYERS if none), its index, and bg_color.
- Stage 2 (edge 2): palette read of bank W at the registered index. If W == NUM_LAYERS, output registered bg_color instead. Register RGB, out_layer and out_valid.
- Latency: exactly 2 Clk from inputs to outputs. Full throughput, one pixel per cycle, no stalls.
- When stage-2 out_valid is 0: VGA_R/G/B are driven to 0 (blanking) and out_layer to NUM_LAYERS.
- Palette storage: NUM_LAYERS x 2^IDX_W entries of 3*COLOR_W bits, written synchronously when pal_we=1.
- Read during write, same entry on the same edge: the stage-2 read returns the old data. The new data is visible from the next edge.
- Entry 0 of every bank is writable but never selected, because index 0 is transparent.
- Collision detection uses stage-1 registered values.
  - For k ≥ 1: set coll_flags[k] when the pixel is valid and both layer 0 and layer k were opaque (pre-priority).
  - Flags are sticky until coll_clr.
  - If coll_clr and a new set occur on the same edge, set wins and the flag reads 1.
  - coll_flags updates 2 cycles after the pixel, aligned with out_valid.
- Reset (asynchronous, Reset_n=0), effective immediately and mid-frame:
  - All pipeline registers cleared.
  - out_valid=0, VGA_R/G/B=0, out_layer=NUM_LAYERS, coll_flags=0.
  - All palette entries cleared to 0 (black).
- After Reset_n deasserts: first valid output 2 edges after the first in_valid=1.
- layer_en=0 for a layer makes it fully transparent, including for collision detection.
- Arithmetic: no wider-than-port constants. All colour values are truncated to COLOR_W by construction.

Test Plan:
1. Reset then palette load: write bank1 idx3 = {0x0A,0xCF,0xFC}. Drive in_valid=1, layer_hit=4'b0010, idx1=3. Required: 2 cycles later out_valid=1, RGB=0A/CF/FC, out_layer=1.
2. Priority and transparency: layers 1 and 2 hit, idx1=0, idx2=5, bank2[5]=FF/FF/00 → RGB FF/FF/00, out_layer=2. Then set idx1=4 with bank1[4]=8C/DE/03 → output 8C/DE/03, out_layer=1.
3. Background and blanking: no hits, bg_color=3F007F → output 3F/00/7F, out_layer=4. Drive in_valid=0 → RGB=0, out_valid=0 two cycles later.
4. Collision sticky/clear: layer0 idx=1 and layer2 idx=2, both hit, for one pixel → coll_flags=4'b0100 stays set through later non-colliding pixels. coll_clr pulse → 0. Pulse coll_clr on the same edge as a new collision → flag remains 1.
5. Read-during-write plus throughput: stream bank1[3] pixels every cycle while writing bank1[3]=112233 on cycle N. The pixel sampled at N-1 (read at edge N) shows the old colour; the pixel from N onward shows 11/22/33. No bubbles in out_valid.
6. Asynchronous reset mid-stream: assert Reset_n=0 between edges → outputs and coll_flags go to 0 / NUM_LAYERS immediately. Palette reads as 0 after release.
